// File: rtl/fm_read_arbiter_pkg.sv
// Shared FM project constants and the read-arbiter state type.
package fm_read_arbiter_pkg;

    localparam int unsigned HASHER_EXTENDER_INDICES_COUNT = 2;
    localparam int unsigned FM_EXTENDER_BYTES_READ_COUNT  = 16;
    localparam int unsigned FM_GENOME_BTYE                = 8;

    localparam int unsigned FM_ARB_NUM_REQ = HASHER_EXTENDER_INDICES_COUNT;
    localparam int unsigned FM_ARB_RD_LAT  = 2;
    localparam int unsigned FM_ARB_ADDR_W  = 8;
    localparam int unsigned FM_PACKET_W    = FM_EXTENDER_BYTES_READ_COUNT * FM_GENOME_BTYE;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RSP
    } fm_arb_state_t;

endpackage

// File: rtl/fm_read_arbiter_if.sv
// Bundle of lane request/response and FM read-port signals around the arbiter.
interface fm_read_arbiter_if
    import fm_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = FM_ARB_NUM_REQ,
    parameter int unsigned ADDR_W  = FM_ARB_ADDR_W,
    parameter int unsigned DATA_W  = FM_PACKET_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fm_rd_en;
    logic [ADDR_W-1:0]         fm_rd_addr;
    logic [DATA_W-1:0]         fm_rd_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    // Lanes plus FM buffer side
    modport master (
        output req_valid, req_addr, fm_rd_data,
        input  req_ready, fm_rd_en, fm_rd_addr, rsp_valid, rsp_data, busy
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, fm_rd_data,
        output req_ready, fm_rd_en, fm_rd_addr, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/fm_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    int unsigned      sum;
    logic [IDX_W-1:0] cand;

    // Walk lanes starting at ptr; the first asserted one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fm_read_arbiter.sv
// Round-robin sharing of the single FM read port among extender lanes.
// One read outstanding: IDLE -> ISSUE -> WAIT -> RSP -> IDLE.
// Optional FM_ARB_PERF_EN adds per-lane saturating grant counters (grant_cnt).
module fm_read_arbiter
    import fm_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = FM_ARB_NUM_REQ,
    parameter int unsigned ADDR_W  = FM_ARB_ADDR_W,
    parameter int unsigned DATA_W  = FM_PACKET_W,
    parameter int unsigned RD_LAT  = FM_ARB_RD_LAT
) (
    input  logic clk,
    input  logic rst,
    fm_read_arbiter_if.slave bus
`ifdef FM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    fm_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, owner_q, ptr_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              fm_rd_en_q;
    logic [ADDR_W-1:0] fm_rd_addr_q, win_addr;
    logic [DATA_W-1:0] rsp_data_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any, grant_fire, last_wait;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Grants only from IDLE and never while reset is held.
    assign grant_fire = (state_q == IDLE) && arb_any && !rst;
    assign last_wait  = (state_q == WAIT) && (cnt_q == CNT_W'(RD_LAT - 1));

    // Select the winner's address and the pointer slot after the winner.
    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_fire) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (last_wait) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs: grant, response pulse, busy.
    always_comb begin
        bus.req_ready = grant_fire ? arb_grant : '0;
        bus.rsp_valid = '0;
        if (state_q == RSP) begin
            bus.rsp_valid[owner_q] = 1'b1;
        end
        bus.busy = (state_q != IDLE);
    end

    // Datapath: latch winner, drive the read strobe, count latency, capture data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            fm_rd_en_q   <= 1'b0;
            fm_rd_addr_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            fm_rd_en_q <= grant_fire;
            if (grant_fire) begin
                owner_q      <= arb_idx;
                fm_rd_addr_q <= win_addr;
                rr_ptr_q     <= ptr_next;
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (last_wait) begin
                rsp_data_q <= bus.fm_rd_data;
            end
        end
    end

    assign bus.fm_rd_en   = fm_rd_en_q;
    assign bus.fm_rd_addr = fm_rd_addr_q;
    assign bus.rsp_data   = rsp_data_q;

`ifdef FM_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;

    // Per-lane grant counters, saturating at 0xFFFF.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i] && bus.req_valid[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fm_read_arbiter.sv
// Directed bench for fm_read_arbiter (2 lanes, RD_LAT=2).
module tb_fm_read_arbiter;
    import fm_read_arbiter_pkg::*;

    localparam int unsigned NR  = 2;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 128;
    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fm_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef FM_ARB_PERF_EN
    logic [NR*16-1:0] grant_cnt;
`endif

    fm_read_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_LAT  (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FM_ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // FM buffer model: data for the strobed address appears two cycles later.
    logic          v1 = 1'b0, v2 = 1'b0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        v1 <= bus.fm_rd_en;
        a1 <= bus.fm_rd_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign bus.fm_rd_data = v2 ? {{15{8'hA5}}, a2} : '0;

    int n_tests = 0;
    int n_fail  = 0;

    int              g_cyc[$], g_lane[$], e_cyc[$], e_addr[$], r_cyc[$], r_vec[$];
    logic [DW-1:0]   r_data[$];
    logic [AW-1:0]   aq0[$], aq1[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [DW-1:0] qd(input logic [DW-1:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    // Observe n cycles from a negedge; on a grant, feed that lane its next
    // queued address or drop its request.
    task automatic run(input int n);
        g_cyc.delete(); g_lane.delete(); e_cyc.delete(); e_addr.delete();
        r_cyc.delete(); r_vec.delete(); r_data.delete();
        for (int c = 0; c < n; c++) begin
            int upd;
            upd = -1;
            #1;
            if (bus.req_ready != '0) begin
                upd = bus.req_ready[1] ? 1 : 0;
                g_cyc.push_back(c);
                g_lane.push_back(upd);
            end
            if (bus.fm_rd_en) begin
                e_cyc.push_back(c);
                e_addr.push_back(int'(bus.fm_rd_addr));
            end
            if (bus.rsp_valid != '0) begin
                r_cyc.push_back(c);
                r_vec.push_back(int'(bus.rsp_valid));
                r_data.push_back(bus.rsp_data);
            end
            @(negedge clk);
            if (upd == 0) begin
                if (aq0.size() > 0) bus.req_addr[7:0] = aq0.pop_front();
                else bus.req_valid[0] = 1'b0;
            end else if (upd == 1) begin
                if (aq1.size() > 0) bus.req_addr[15:8] = aq1.pop_front();
                else bus.req_valid[1] = 1'b0;
            end
        end
    endtask

    int           exp_lane[4] = '{0, 1, 0, 1};
    logic [7:0]   exp_addr[4] = '{8'h30, 8'h31, 8'h32, 8'h33};

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values, with requests pending while reset is held
        bus.req_valid = 2'b11;
        #1;
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_fm_rd_en", bus.fm_rd_en, 1'b0);
        check("rst_fm_rd_addr", bus.fm_rd_addr, 8'h00);
        check("rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_busy", bus.busy, 1'b0);
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request from lane 0
        bus.req_valid = 2'b01;
        bus.req_addr  = 16'h0012;
        run(6);
        check("t1_ngrant", g_cyc.size(), 1);
        check("t1_grant_lane", qi(g_lane, 0), 0);
        check("t1_en_cyc", qi(e_cyc, 0), 1);
        check("t1_en_addr", qi(e_addr, 0), 32'h12);
        check("t1_nen", e_cyc.size(), 1);
        check("t1_rsp_cyc", qi(r_cyc, 0), 4);
        check("t1_rsp_vec", qi(r_vec, 0), 1);
        check("t1_rsp_data", qd(r_data, 0), {{15{8'hA5}}, 8'h12});
        #1;
        check("t1_idle_busy", bus.busy, 1'b0);
        check("t1_hold_data", bus.rsp_data, {{15{8'hA5}}, 8'h12});
        @(negedge clk);

        // Back-to-back from lane 1: 0x01 then 0x02
        bus.req_valid = 2'b10;
        bus.req_addr  = 16'h0100;
        aq1.push_back(8'h02);
        run(11);
        check("t2_ngrant", g_cyc.size(), 2);
        check("t2_grant0_cyc", qi(g_cyc, 0), 0);
        check("t2_grant1_cyc", qi(g_cyc, 1), 5);
        check("t2_lane", qi(g_lane, 1), 1);
        check("t2_en_addr0", qi(e_addr, 0), 32'h01);
        check("t2_en_addr1", qi(e_addr, 1), 32'h02);
        check("t2_rsp_cyc0", qi(r_cyc, 0), 4);
        check("t2_rsp_cyc1", qi(r_cyc, 1), 9);
        check("t2_rsp_vec1", qi(r_vec, 1), 2);
        check("t2_rsp_data0", qd(r_data, 0), {{15{8'hA5}}, 8'h01});
        check("t2_rsp_data1", qd(r_data, 1), {{15{8'hA5}}, 8'h02});

        // Contention: both lanes held high, pointer back at lane 0
        bus.req_valid = 2'b11;
        bus.req_addr  = 16'h3130;
        aq0.push_back(8'h32);
        aq1.push_back(8'h33);
        run(20);
        check("t3_ngrant", g_cyc.size(), 4);
        check("t3_nrsp", r_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_lane%0d", i), qi(g_lane, i), exp_lane[i]);
            check($sformatf("t3_gcyc%0d", i), qi(g_cyc, i), 5 * i);
            check($sformatf("t3_rvec%0d", i), qi(r_vec, i), 1 << exp_lane[i]);
            check($sformatf("t3_rdata%0d", i), qd(r_data, i), {{15{8'hA5}}, exp_addr[i]});
        end

        // Lane 1 raises and withdraws its request while lane 0 is served
        bus.req_valid = 2'b01;
        bus.req_addr  = 16'h0040;
        #1;
        check("t4_grant0", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid = 2'b10;
        bus.req_addr  = 16'h7740;
        #1;
        check("t4_no_grant_issue", bus.req_ready, 2'b00);
        check("t4_en", bus.fm_rd_en, 1'b1);
        check("t4_en_addr", bus.fm_rd_addr, 8'h40);
        @(negedge clk);
        bus.req_valid = 2'b00;
        run(8);
        check("t4_ngrant", g_cyc.size(), 0);
        check("t4_nen", e_cyc.size(), 0);
        check("t4_nrsp", r_cyc.size(), 1);
        check("t4_rsp_cyc", qi(r_cyc, 0), 2);
        check("t4_rsp_vec", qi(r_vec, 0), 1);

        // Reset in WAIT: read discarded, pointer back to 0
        bus.req_valid = 2'b01;
        bus.req_addr  = 16'h0050;
        #1;
        check("t5_grant0", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_en", bus.fm_rd_en, 1'b0);
        check("t5_rsp", bus.rsp_valid, 2'b00);
        @(negedge clk);
        run(6);
        check("t5_nrsp", r_cyc.size(), 0);
        check("t5_nen", e_cyc.size(), 0);
        bus.req_valid = 2'b11;
        bus.req_addr  = 16'h6160;
        run(10);
        check("t5_ngrant", g_cyc.size(), 2);
        check("t5_first_lane", qi(g_lane, 0), 0);
        check("t5_second_lane", qi(g_lane, 1), 1);

`ifdef FM_ARB_PERF_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("p_rst", grant_cnt, 32'h0);
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_addr  = 16'h0201;
        aq0.push_back(8'h03);
        aq0.push_back(8'h05);
        aq1.push_back(8'h04);
        run(25);
        check("p_counts", grant_cnt, {16'd2, 16'd3});
        force dut.grant_cnt_q = {16'd2, 16'hFFFE};
        #1;
        release dut.grant_cnt_q;
        bus.req_valid = 2'b01;
        bus.req_addr  = 16'h0009;
        aq0.push_back(8'h0A);
        run(11);
        check("p_sat", grant_cnt, {16'd2, 16'hFFFF});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
